// File: rtl/fetch_ir_unit.sv
// fetch_ir_unit: program counter, branch resolve and instruction register stage
// of the multicycle MIPS core. It fetches the instruction word over a
// request/acknowledge memory port and raises Stall while a fetch is outstanding.
// Optional feature macro: FETCH_TIMEOUT_EN (abandon a fetch after TIMEOUT
// unacknowledged WAIT cycles, load a nop and set a sticky FetchErr).
module fetch_ir_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        PCWrite,
  input  logic        BranchEq,
  input  logic        BranchNeq,
  input  logic        PCSrc,
  input  logic        IRWrite,
  input  logic        Zero,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ALUOut,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic        Stall,
  output logic        FetchErr
);

  localparam int unsigned CNT_W = (TIMEOUT > 15) ? $clog2(TIMEOUT + 1) : 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state;
  logic   pc_en;

  // A zero timeout would abandon every fetch on its first WAIT cycle.
  if (TIMEOUT == 0) begin : g_timeout_check
    $error("fetch_ir_unit: TIMEOUT must be nonzero");
  end

  // PC write enable: unconditional write or a taken branch.
  always_comb begin
    pc_en = PCWrite | (BranchEq & Zero) | (BranchNeq & ~Zero);
  end

  // Program counter; updates are honoured in every fetch state.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      PC <= RESET_PC;
    end else if (pc_en) begin
      PC <= PCSrc ? ALUOut : ALUResult;
    end
  end

  // Decode fields are plain slices of the instruction register.
  assign Op    = Instr[31:26];
  assign Funct = Instr[5:0];

`ifdef FETCH_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // Fetch FSM with abandon-on-timeout; an ack in the timeout cycle still wins.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= S_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0000_0000;
      Instr    <= 32'h0000_0000;
      Stall    <= 1'b0;
      FetchErr <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (IRWrite) begin
            mem_addr <= PC;
            mem_req  <= 1'b1;
            Stall    <= 1'b1;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            Instr   <= mem_rdata;
            mem_req <= 1'b0;
            Stall   <= 1'b0;
            state   <= S_IDLE;
          end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            Instr    <= 32'h0000_0000;
            mem_req  <= 1'b0;
            Stall    <= 1'b0;
            FetchErr <= 1'b1;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  // Without the timeout feature a fetch can never be abandoned.
  assign FetchErr = 1'b0;

  // Fetch FSM: issue the request in IDLE, wait for the ack in WAIT.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= S_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0000_0000;
      Instr    <= 32'h0000_0000;
      Stall    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (IRWrite) begin
            mem_addr <= PC;
            mem_req  <= 1'b1;
            Stall    <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            Instr   <= mem_rdata;
            mem_req <= 1'b0;
            Stall   <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ir_unit.sv
// Self-checking bench for fetch_ir_unit: expected instruction words are pushed
// to a scoreboard when a fetch is issued and popped when Stall falls.
module tb_fetch_ir_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        PCWrite = 1'b0, BranchEq = 1'b0, BranchNeq = 1'b0, PCSrc = 1'b0;
  logic        IRWrite = 1'b0, Zero = 1'b0, mem_ack = 1'b0;
  logic [31:0] ALUResult = '0, ALUOut = '0, mem_rdata = '0;
  logic        mem_req, Stall, FetchErr;
  logic [31:0] mem_addr, PC, Instr;
  logic [5:0]  Op, Funct;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  fetch_ir_unit #(.RESET_PC(RST_PC), .TIMEOUT(15)) dut (
    .CLK(CLK), .CLR(CLR), .PCWrite(PCWrite), .BranchEq(BranchEq),
    .BranchNeq(BranchNeq), .PCSrc(PCSrc), .IRWrite(IRWrite), .Zero(Zero),
    .ALUResult(ALUResult), .ALUOut(ALUOut), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_addr(mem_addr), .PC(PC),
    .Instr(Instr), .Op(Op), .Funct(Funct), .Stall(Stall), .FetchErr(FetchErr)
  );

  always #5 CLK = ~CLK;

  // All tasks start and end just after a falling edge.
  task automatic test_reset();
    CLR = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++; if (PC !== RST_PC) begin n_err++; $display("FAIL reset_pc got %h want %h", PC, RST_PC); end
    n_cmp++; if (Instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", Instr); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", Stall); end
    n_cmp++; if (FetchErr !== 1'b0) begin n_err++; $display("FAIL reset_fetcherr got %b want 0", FetchErr); end
    CLR = 1'b0;
    exp_pc = RST_PC;
    @(negedge CLK);
    n_cmp++; if (PC !== RST_PC) begin n_err++; $display("FAIL reset_pc_hold got %h want %h", PC, RST_PC); end
  endtask

  // One cycle of PC strobes; the expected PC follows the enable equation.
  task automatic pc_step(input logic pcw, input logic beq, input logic bne,
                         input logic z, input logic src,
                         input logic [31:0] res, input logic [31:0] out,
                         input string name);
    PCWrite = pcw; BranchEq = beq; BranchNeq = bne; Zero = z; PCSrc = src;
    ALUResult = res; ALUOut = out;
    @(negedge CLK);
    PCWrite = 1'b0; BranchEq = 1'b0; BranchNeq = 1'b0; PCSrc = 1'b0;
    if (pcw | (beq & z) | (bne & ~z)) exp_pc = src ? out : res;
    n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL %s pc got %h want %h", name, PC, exp_pc); end
  endtask

  // Pop the scoreboard and compare the instruction register and its fields.
  task automatic check_instr(input string name);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL %s scoreboard empty, instr %h", name, Instr);
    end else begin
      e = exp_q.pop_front();
      if (Instr !== e) begin n_err++; $display("FAIL %s instr got %h want %h", name, Instr, e); end
      n_cmp++; if (Op !== e[31:26]) begin n_err++; $display("FAIL %s op got %h want %h", name, Op, e[31:26]); end
      n_cmp++; if (Funct !== e[5:0]) begin n_err++; $display("FAIL %s funct got %h want %h", name, Funct, e[5:0]); end
    end
  endtask

  // Full fetch with the ack driven so that Stall is high for 'delay' cycles.
  task automatic fetch(input logic [31:0] next_pc, input logic adv,
                       input logic [31:0] data, input int delay, input string name);
    logic [31:0] addr;
    int          stall_cnt;
    addr = exp_pc;
    IRWrite = 1'b1; PCWrite = adv; PCSrc = 1'b0; ALUResult = next_pc;
    exp_q.push_back(data);
    @(negedge CLK);
    IRWrite = 1'b0; PCWrite = 1'b0;
    if (adv) exp_pc = next_pc;
    n_cmp++; if (mem_addr !== addr) begin n_err++; $display("FAIL %s mem_addr got %h want %h", name, mem_addr, addr); end
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL %s mem_req got %b want 1", name, mem_req); end
    n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL %s pc got %h want %h", name, PC, exp_pc); end
    stall_cnt = 0;
    while (Stall === 1'b1 && stall_cnt < 64) begin
      stall_cnt++;
      if (stall_cnt == delay) begin mem_ack = 1'b1; mem_rdata = data; end
      @(negedge CLK);
      mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    end
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL %s stall_timeout got %b want 0", name, Stall); end
    n_cmp++; if (stall_cnt != delay) begin n_err++; $display("FAIL %s stall_cycles got %0d want %0d", name, stall_cnt, delay); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL %s mem_req_drop got %b want 0", name, mem_req); end
    check_instr(name);
  endtask

  task automatic test_fetch();
    pc_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, "set_pc");
    fetch(32'h0000_0014, 1'b1, 32'h0109_5020, 3, "fetch");
    n_cmp++; if (Op !== 6'h00) begin n_err++; $display("FAIL fetch_op got %h want 00", Op); end
    n_cmp++; if (Funct !== 6'h20) begin n_err++; $display("FAIL fetch_funct got %h want 20", Funct); end
  endtask

  task automatic test_branches();
    pc_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0999, 32'h0000_0080, "beq_taken");
    pc_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0999, 32'h0000_0120, "beq_not_taken");
    pc_step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0999, 32'h0000_0200, "bne_not_taken");
    pc_step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0999, 32'h0000_0040, "bne_taken");
    pc_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0999, 32'h0000_0033, "pcwrite_aluout");
    pc_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0777, "pcwrite_result");
  endtask

  // IRWrite in WAIT is ignored, a PC write in WAIT is honoured, ack in IDLE is ignored.
  task automatic test_ignored();
    IRWrite = 1'b1;
    exp_q.push_back(32'h8C22_0004);
    @(negedge CLK);
    IRWrite = 1'b0;
    n_cmp++; if (mem_addr !== 32'h0000_0040) begin n_err++; $display("FAIL ign_addr got %h want 00000040", mem_addr); end
    IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 1'b0; ALUResult = 32'h0000_0044;
    @(negedge CLK);
    IRWrite = 1'b0; PCWrite = 1'b0;
    exp_pc = 32'h0000_0044;
    n_cmp++; if (mem_addr !== 32'h0000_0040) begin n_err++; $display("FAIL ign_addr_held got %h want 00000040", mem_addr); end
    n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL ign_pc_in_wait got %h want %h", PC, exp_pc); end
    n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL ign_stall got %b want 1", Stall); end
    mem_ack = 1'b1; mem_rdata = 32'h8C22_0004;
    @(negedge CLK);
    mem_ack = 1'b0;
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL ign_stall_done got %b want 0", Stall); end
    check_instr("ign_fetch");
    @(negedge CLK);
    n_cmp++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin n_err++; $display("FAIL ign_second_fetch req %b stall %b want 0 0", mem_req, Stall); end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge CLK);
    mem_ack = 1'b0;
    n_cmp++; if (Instr !== 32'h8C22_0004) begin n_err++; $display("FAIL ign_idle_ack got %h want 8c220004", Instr); end
  endtask

  task automatic test_reset_mid_fetch();
    IRWrite = 1'b1;
    @(negedge CLK);
    IRWrite = 1'b0;
    @(negedge CLK);
    n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL rmf_in_wait got %b want 1", Stall); end
    CLR = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin n_err++; $display("FAIL rmf_async req %b stall %b want 0 0", mem_req, Stall); end
    n_cmp++; if (PC !== RST_PC) begin n_err++; $display("FAIL rmf_pc got %h want %h", PC, RST_PC); end
    @(negedge CLK);
    CLR = 1'b0;
    exp_pc = RST_PC;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge CLK);
    mem_ack = 1'b0;
    n_cmp++; if (Instr !== 32'h0) begin n_err++; $display("FAIL rmf_late_ack instr got %h want 0", Instr); end
    n_cmp++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin n_err++; $display("FAIL rmf_idle req %b stall %b want 0 0", mem_req, Stall); end
  endtask

  task automatic test_back_to_back();
    fetch(RST_PC + 32'd4, 1'b1, 32'h2008_0005, 1, "b2b0");
    fetch(RST_PC + 32'd8, 1'b1, 32'h0230_402A, 1, "b2b1");
    fetch(RST_PC + 32'd12, 1'b1, 32'h1109_FFFC, 2, "b2b2");
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    IRWrite = 1'b1;
    @(negedge CLK);
    IRWrite = 1'b0;
    cyc = 0;
    while (Stall === 1'b1 && cyc < 64) begin cyc++; @(negedge CLK); end
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL to_abandon stall got %b want 0", Stall); end
    n_cmp++; if (Instr !== 32'h0) begin n_err++; $display("FAIL to_instr got %h want 0", Instr); end
    n_cmp++; if (FetchErr !== 1'b1) begin n_err++; $display("FAIL to_err got %b want 1", FetchErr); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL to_req got %b want 0", mem_req); end
    fetch(exp_pc + 32'd4, 1'b1, 32'h0000_0020, 2, "to_after");
    n_cmp++; if (FetchErr !== 1'b1) begin n_err++; $display("FAIL to_sticky got %b want 1", FetchErr); end
  endtask
`else
  // A long wait is never abandoned in this build.
  task automatic test_long_wait();
    fetch(exp_pc + 32'd4, 1'b1, 32'hAC43_0008, 20, "long_wait");
    n_cmp++; if (FetchErr !== 1'b0) begin n_err++; $display("FAIL long_wait_err got %b want 0", FetchErr); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_branches();
    test_ignored();
    test_reset_mid_fetch();
    test_back_to_back();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
